// File: rtl/andla_ldma_pkg.sv
// andla_ldma_pkg: shared FSM state, beat type and default widths for the LDMA roll address generator
package andla_ldma_pkg;
  localparam int LDMA_ADDR_W = 20;
  localparam int LDMA_SIZE_W = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
  typedef struct packed {
    logic [LDMA_ADDR_W-1:0] addr;
    logic pad;
    logic eol;
    logic last;
  } beat_t;
endpackage

// File: rtl/andla_ldma_sfifo.sv
// andla_ldma_sfifo: synchronous FIFO with flush; head is zeroed while empty
module andla_ldma_sfifo
  import andla_ldma_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = beat_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  T     wr_data,
  output T     rd_data,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign do_pop = pop && !empty;
  assign rd_data = empty ? '0 : mem[rp_q];
  always_comb begin
    wp_d = flush ? '0 : wp_q + AW'(push);
    rp_d = flush ? '0 : rp_q + AW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp_q] <= wr_data;
  end
endmodule

// File: rtl/andla_ldma_roll_agen.sv
// andla_ldma_roll_agen: walks the padded plane emitting address/pad beats through a skid FIFO.
// Define ANDLA_LDMA_ROLL_PERF_EN to add the perf_stall_cnt output.
module andla_ldma_roll_agen
  import andla_ldma_pkg::*;
#(
  parameter int ADDR_W = LDMA_ADDR_W,
  parameter int SIZE_W = LDMA_SIZE_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [SIZE_W-1:0] cfg_row_len,
  input  logic [SIZE_W-1:0] cfg_row_stride,
  input  logic [SIZE_W-1:0] cfg_rows,
  input  logic [SIZE_W-1:0] cfg_pad_left,
  input  logic [SIZE_W-1:0] cfg_pad_right,
  input  logic [SIZE_W-1:0] cfg_pad_h,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_pad,
  output logic              out_eol,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef ANDLA_LDMA_ROLL_PERF_EN
  , output logic [31:0]     perf_stall_cnt
`endif
);
  localparam int XW = SIZE_W + 2;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic pad;
    logic eol;
    logic last;
  } lbeat_t;
  state_t state_q, state_d;
  logic [XW-1:0] c_q, c_d, r_q, r_d, w_q, w_d, h_q, h_d;
  logic [XW-1:0] pl_q, pl_d, pe_q, pe_d, ph_q, ph_d, phe_q, phe_d;
  logic [SIZE_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic busy_q, busy_d, done_q, done_d;
  logic full, empty, push, pop, go, kill, eol, last, pad;
  logic [XW-1:0] wn, hn;
  lbeat_t beat, head;
  assign go = start && !abort && state_q == ST_IDLE;
  assign kill = abort && state_q != ST_IDLE;
  assign wn = XW'(cfg_pad_left) + XW'(cfg_row_len) + XW'(cfg_pad_right);
  assign hn = XW'(cfg_pad_h) + XW'(cfg_pad_h) + XW'(cfg_rows);
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push = state_q == ST_RUN && !abort && (!full || pop);
  assign eol = c_q == w_q - 1'b1;
  assign last = eol && r_q == h_q - 1'b1;
  assign pad = r_q < ph_q || r_q >= phe_q || c_q < pl_q || c_q >= pe_q;
  assign beat.addr = pad ? '0 : row_q + ADDR_W'(c_q - pl_q);
  assign beat.pad = pad;
  assign beat.eol = eol;
  assign beat.last = last;
  always_comb begin
    state_d = state_q;
    c_d = c_q;
    r_d = r_q;
    w_d = w_q;
    h_d = h_q;
    pl_d = pl_q;
    pe_d = pe_q;
    ph_d = ph_q;
    phe_d = phe_q;
    stride_d = stride_q;
    row_d = row_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (kill) begin
      state_d = ST_IDLE;
      busy_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (go) begin
          pl_d = XW'(cfg_pad_left);
          pe_d = XW'(cfg_pad_left) + XW'(cfg_row_len);
          ph_d = XW'(cfg_pad_h);
          phe_d = XW'(cfg_pad_h) + XW'(cfg_rows);
          w_d = wn;
          h_d = hn;
          stride_d = cfg_row_stride;
          row_d = cfg_base_addr;
          c_d = '0;
          r_d = '0;
          state_d = (wn == '0 || hn == '0) ? ST_DONE : ST_RUN;
          busy_d = !(wn == '0 || hn == '0);
        end
        ST_RUN: if (push) begin
          c_d = eol ? '0 : c_q + 1'b1;
          r_d = eol ? r_q + 1'b1 : r_q;
          row_d = (eol && r_q >= ph_q && r_q < phe_q) ? row_q + ADDR_W'(stride_q) : row_q;
          state_d = last ? ST_DRAIN : ST_RUN;
        end
        ST_DRAIN: if (empty) begin
          state_d = ST_DONE;
          busy_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          done_d = 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      c_q <= '0;
      r_q <= '0;
      w_q <= '0;
      h_q <= '0;
      pl_q <= '0;
      pe_q <= '0;
      ph_q <= '0;
      phe_q <= '0;
      stride_q <= '0;
      row_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      r_q <= r_d;
      w_q <= w_d;
      h_q <= h_d;
      pl_q <= pl_d;
      pe_q <= pe_d;
      ph_q <= ph_d;
      phe_q <= phe_d;
      stride_q <= stride_d;
      row_q <= row_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  andla_ldma_sfifo #(.DEPTH(FIFO_DEPTH), .T(lbeat_t)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(kill),
    .push(push),
    .pop(pop),
    .wr_data(beat),
    .rd_data(head),
    .full(full),
    .empty(empty)
  );
  assign out_addr = head.addr;
  assign out_pad = head.pad;
  assign out_eol = head.eol;
  assign out_last = head.last;
  assign busy = busy_q;
  assign done = done_q;
`ifdef ANDLA_LDMA_ROLL_PERF_EN
  logic [31:0] perf_q, perf_d;
  always_comb perf_d = go ? '0 : ((state_q == ST_RUN || state_q == ST_DRAIN) && out_valid && !out_ready && perf_q != '1) ? perf_q + 1'b1 : perf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else perf_q <= perf_d;
  end
  assign perf_stall_cnt = perf_q;
`endif
endmodule

// File: tb/tb_andla_ldma_roll_agen.sv
// tb_andla_ldma_roll_agen: directed and randomized walks checked against a plane-level reference model
module tb_andla_ldma_roll_agen;
  localparam int AW = 20;
  localparam int SW = 16;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic pad;
    logic eol;
    logic last;
  } bt_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [SW-1:0] cfg_row_len = '0, cfg_row_stride = '0, cfg_rows = '0;
  logic [SW-1:0] cfg_pad_left = '0, cfg_pad_right = '0, cfg_pad_h = '0;
  logic out_valid, out_pad, out_eol, out_last, busy, done;
  logic [AW-1:0] out_addr;
`ifdef ANDLA_LDMA_ROLL_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif
  int vectors = 0, errs = 0;
  bt_t exp_q[$];
  andla_ldma_roll_agen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_row_len(cfg_row_len), .cfg_row_stride(cfg_row_stride),
    .cfg_rows(cfg_rows), .cfg_pad_left(cfg_pad_left), .cfg_pad_right(cfg_pad_right), .cfg_pad_h(cfg_pad_h),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_pad(out_pad),
    .out_eol(out_eol), .out_last(out_last), .busy(busy), .done(done)
`ifdef ANDLA_LDMA_ROLL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bt_t cur();
    bt_t b;
    b.addr = out_addr;
    b.pad = out_pad;
    b.eol = out_eol;
    b.last = out_last;
    return b;
  endfunction
  // the expected plane: real element (i, j) sits at base + i*stride + j
  task automatic setup(input int base, input int rl, input int st, input int rows, input int pl, input int pr, input int ph);
    int w, h;
    bt_t b;
    bit is_real;
    longint a;
    cfg_base_addr = AW'(base);
    cfg_row_len = SW'(rl);
    cfg_row_stride = SW'(st);
    cfg_rows = SW'(rows);
    cfg_pad_left = SW'(pl);
    cfg_pad_right = SW'(pr);
    cfg_pad_h = SW'(ph);
    w = pl + rl + pr;
    h = 2 * ph + rows;
    exp_q.delete();
    if (w == 0 || h == 0) return;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        is_real = r >= ph && r < ph + rows && c >= pl && c < pl + rl;
        a = is_real ? (longint'(base) + longint'(r - ph) * st + (c - pl)) % (longint'(1) << AW) : 0;
        b.addr = AW'(a);
        b.pad = !is_real;
        b.eol = c == w - 1;
        b.last = c == w - 1 && r == h - 1;
        exp_q.push_back(b);
      end
  endtask
  // mode 0: ready high, 1: ready toggles, 2: random ready
  task automatic run(input int mode, input int abort_at, input int restart_at);
    int k = 0, n = 0, dones = 0, stalls = 0, last_k = -1, done_k = -1;
    int total = exp_q.size();
    bt_t held;
    bit holding = 0, dn;
    @(negedge clk);
    start = 1'b1;
    while (k < 3000 && !(done_k >= 0 && k >= done_k + 3)) begin
      @(negedge clk);
      k++;
      start = k == restart_at;
      if (k == 3) begin
        cfg_base_addr = AW'($urandom);
        cfg_row_len = SW'($urandom);
        cfg_rows = SW'($urandom);
        cfg_pad_left = SW'($urandom);
        cfg_row_stride = SW'($urandom);
      end
      if (holding) chk("stall hold", cur(), held);
      holding = 0;
      if (done) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
      if (k == 1) chk("busy after start", busy, total > 0);
      if (k == 2 && total > 0) chk("first valid latency", out_valid, 1);
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (k % 2 == 1) : ($urandom_range(0, 3) != 0);
      if (out_valid && abort_at >= 0 && n == abort_at) begin
        abort = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk("abort valid", out_valid, 0);
        chk("abort busy", busy, 0);
        dn = done;
        repeat (6) begin
          @(negedge clk);
          dn = dn | done;
        end
        chk("abort no done", dn, 0);
        return;
      end
      if (out_valid && out_ready) begin
        if (n < total) chk($sformatf("beat %0d", n), cur(), exp_q[n]);
        if (out_last) last_k = k;
        n++;
      end else if (out_valid) begin
        stalls++;
        held = cur();
        holding = 1;
      end
    end
    chk("walk timeout", k < 3000, 1);
    chk("beat count", n, total);
    chk("done pulses", dones, 1);
    chk("busy after done", busy, 0);
    if (total > 0) chk("done after last", done_k > last_k && done_k <= last_k + 3, 1);
    else chk("empty done latency", done_k, 2);
`ifdef ANDLA_LDMA_ROLL_PERF_EN
    chk("perf stall count", perf_stall_cnt, stalls);
`endif
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset outputs", {out_valid, out_addr, out_pad, out_eol, out_last, busy, done}, 0);
    rst = 1'b0;
    @(negedge clk);
    setup('h100, 4, 8, 2, 1, 1, 1);
    run(0, -1, -1);
    setup('h100, 4, 8, 2, 1, 1, 1);
    run(1, -1, -1);
    setup('h100, 4, 8, 0, 1, 1, 0);
    run(0, -1, -1);
    setup('h100, 4, 8, 2, 1, 1, 1);
    run(0, 10, -1);
    setup('h100, 4, 8, 2, 1, 1, 1);
    run(0, -1, -1);
    setup('h100, 4, 8, 2, 1, 1, 1);
    run(0, -1, 8);
    setup('hFFFFE, 4, 0, 1, 0, 0, 0);
    run(0, -1, -1);
    for (int i = 0; i < 5; i++) begin
      setup(int'($urandom_range(0, (1 << AW) - 1)), int'($urandom_range(0, 5)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      run(2, -1, -1);
    end
    setup('h100, 4, 8, 2, 1, 1, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async reset", {out_valid, out_addr, out_pad, out_eol, out_last, busy, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    setup('h100, 4, 8, 2, 1, 1, 1);
    run(2, -1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
